unsigned_seq_divider: RTL and testbench



---
 rtl/unsigned_seq_divider_if.sv | 32 +++
 rtl/unsigned_seq_divider.sv | 131 +++++++++++++
 tb/tb_unsigned_seq_divider.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_seq_divider_if.sv
// rtl/unsigned_seq_divider_if.sv - request/result bundle between the ALU and the divider
// Ports (master = ALU side, slave = divider side):
//   start        master->slave  single-cycle divide request
//   dividend     master->slave  unsigned numerator, sampled with start
//   divisor      master->slave  unsigned denominator, sampled with start
//   busy         slave->master  division in progress
//   done         slave->master  one-cycle pulse, results updated
//   quotient     slave->master  registered quotient
//   remainder    slave->master  registered remainder
//   div_by_zero  slave->master  registered divide-by-zero flag
interface unsigned_seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/unsigned_seq_divider.sv
// rtl/unsigned_seq_divider.sv - restoring unsigned divider, one quotient bit per clock
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of unsigned_seq_divider_if (start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out, all outputs registered)
module unsigned_seq_divider #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  unsigned_seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] q_q;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_q;        // partial remainder; always < divisor so 32 bits hold it
  logic [WIDTH-1:0] d_q;
  logic             zpend_q;    // divide-by-zero result due on the next edge
  logic [WIDTH-1:0] zdvd_q;

  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             accept, accept_zero, last_iter;
  logic [WIDTH:0]   r_shift, trial;
  logic [WIDTH-1:0] r_next, q_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; divide-by-zero never leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && (bus.divisor != '0)) state_d = DIV;
      DIV:  if (count_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept      = 1'b0;
    accept_zero = 1'b0;
    last_iter   = 1'b0;
    case (state_q)
      IDLE: begin
        accept      = bus.start && (bus.divisor != '0);
        accept_zero = bus.start && (bus.divisor == '0);
      end
      DIV:  last_iter = (count_q == LAST);
      default: ;
    endcase
  end

  // One restoring step: a borrow out of the 33-bit trial means restore.
  // When r_shift[WIDTH] is set the trial can never borrow, so the kept
  // remainder always fits in WIDTH bits.
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_q};
  assign r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  // Working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      zpend_q <= 1'b0;
      zdvd_q  <= '0;
    end else begin
      zpend_q <= accept_zero;
      if (accept_zero) zdvd_q <= bus.dividend;
      if (accept) begin
        q_q     <= bus.dividend;
        r_q     <= '0;
        d_q     <= bus.divisor;
        count_q <= '0;
      end else if (state_q == DIV) begin
        q_q     <= q_next;
        r_q     <= r_next;
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Result registers; they only move on a done edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= (state_d == DIV);
      done_q <= last_iter | zpend_q;
      if (last_iter) begin
        quot_q <= q_next;
        rem_q  <= r_next;
        dbz_q  <= 1'b0;
      end else if (zpend_q) begin
        quot_q <= '1;
        rem_q  <= zdvd_q;
        dbz_q  <= 1'b1;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_seq_divider.sv
// tb/tb_unsigned_seq_divider.sv - directed and random checks of unsigned_seq_divider
module tb_unsigned_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  unsigned_seq_divider_if #(.WIDTH(32)) bus();

  unsigned_seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;
  int busy_cnt = 0;
  int held_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge
  logic        smp_start = 1'b0;
  logic        smp_rst   = 1'b1;
  logic [31:0] smp_a = '0, smp_b = '0;
  always @(posedge clk) begin
    smp_start <= bus.start;
    smp_a     <= bus.dividend;
    smp_b     <= bus.divisor;
    smp_rst   <= rst;
  end

  // Behavioural model: a divide is a countdown of 32 edges ending in a/b, a%b
  int          m_left = 0;
  logic        m_dbzp = 1'b0, m_done = 1'b0, m_busy = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0, m_pa = '0, m_pb = '0, m_za = '0;
  bit          idle_before;

  always @(negedge clk) begin
    if (rst || smp_rst) begin
      m_left = 0; m_dbzp = 0; m_done = 0; m_busy = 0; m_dbz = 0; m_q = '0; m_r = '0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quotient", bus.quotient, 0);
    end else begin
      m_done = 0;
      idle_before = (m_left == 0);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_busy = 0; m_dbz = 0; m_q = m_pq; m_r = m_pr;
        end
      end
      if (m_dbzp) begin
        m_done = 1; m_dbz = 1; m_q = 32'hFFFFFFFF; m_r = m_za; m_dbzp = 0;
      end
      if (idle_before && smp_start) begin
        if (smp_b != 0) begin
          m_left = 32; m_busy = 1;
          m_pq = smp_a / smp_b; m_pr = smp_a % smp_b; m_pa = smp_a; m_pb = smp_b;
        end else begin
          m_dbzp = 1; m_za = smp_a;
        end
      end
      chk("m_done", bus.done, m_done);
      chk("m_busy", bus.busy, m_busy);
      chk("m_quotient", bus.quotient, m_q);
      chk("m_remainder", bus.remainder, m_r);
      chk("m_div_by_zero", bus.div_by_zero, m_dbz);
      if (m_done && !m_dbz) begin
        chk("invariant", ({32'b0, bus.quotient} * {32'b0, m_pb}) + {32'b0, bus.remainder}, {32'b0, m_pa});
        chk("rem_lt_div", bus.remainder < m_pb, 1);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t_acc = cyc;
    busy_cnt = bus.busy;
  endtask

  task automatic wait_done(input int max, output int lat);
    bit seen = 0;
    logic [31:0] q0 = bus.quotient;
    logic [31:0] r0 = bus.remainder;
    held_bad = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1;
      else begin
        busy_cnt += bus.busy;
        if (bus.quotient !== q0 || bus.remainder !== r0) held_bad = 1;
      end
    end
    chk("done_seen", seen, 1);
    lat = cyc - t_acc;
  endtask

  task automatic div_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat, input int ebusy);
    int lat;
    issue(a, b);
    wait_done(40, lat);
    chk({name, "_latency"}, lat, elat);
    chk({name, "_quotient"}, bus.quotient, eq);
    chk({name, "_remainder"}, bus.remainder, er);
    chk({name, "_div_by_zero"}, bus.div_by_zero, edbz);
    chk({name, "_busy_cycles"}, busy_cnt, ebusy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, first_done, ndone;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_quotient", bus.quotient, 0);
    chk("reset_remainder", bus.remainder, 0);
    chk("reset_div_by_zero", bus.div_by_zero, 0);

    div_case("100_7", 100, 7, 14, 2, 0, 32, 32);
    div_case("max_1", 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 32, 32);
    div_case("3_10", 3, 10, 0, 3, 0, 32, 32);
    div_case("msb_max", 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 32, 32);
    div_case("5_0", 5, 0, 32'hFFFFFFFF, 5, 1, 1, 0);
    div_case("9_3", 9, 3, 3, 0, 0, 32, 32);

    // start pulse with new operands while busy is ignored
    issue(1000, 9);
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 50; bus.divisor = 5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(40, lat);
    chk("ignored_start_latency", lat, 32);
    chk("ignored_start_quotient", bus.quotient, 111);
    chk("ignored_start_remainder", bus.remainder, 1);
    ndone = 0;
    repeat (35) begin @(posedge clk); #1; ndone += bus.done; end
    chk("ignored_start_no_extra_done", ndone, 0);

    // back-to-back: second start issued in the done cycle
    issue(1000, 9);
    wait_done(40, lat);
    first_done = cyc;
    chk("b2b_first_quotient", bus.quotient, 111);
    issue(50, 5);
    wait_done(40, lat);
    chk("b2b_spacing", cyc - first_done, 33);
    chk("b2b_first_held", held_bad, 0);
    chk("b2b_second_quotient", bus.quotient, 10);
    chk("b2b_second_remainder", bus.remainder, 0);

    // asynchronous reset in the middle of cycle 15
    issue(1000, 9);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_quotient", bus.quotient, 0);
    chk("async_rst_remainder", bus.remainder, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_dbz", bus.div_by_zero, 0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; ndone += bus.done; end
    chk("async_rst_no_done", ndone, 0);

    // start held high re-triggers at every return to IDLE
    bus.start = 1'b1; bus.dividend = 20; bus.divisor = 6;
    repeat (70) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    chk("held_start_quotient", bus.quotient, 3);
    chk("held_start_remainder", bus.remainder, 2);

    // random operands, checked by the model and the invariant
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = a >> $urandom_range(0, 31);
        default: b = (i % 20 == 3) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      issue(a, b);
      wait_done(40, lat);
    end
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
